keypad_entry_ctrl: RTL and testbench

Sequences operand entry from the 16-button keypad into the digit RAM.
- Synchronizes, one-hot-validates and debounces raw buttons, then performs one action per press: write digit, backspace, clear or enter.
- Drives RAM write-enable, address and data, and reports entry length to the display/operation logic.
- Sits between the raw button pins and the digit RAM, in the oscillator clock domain.

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_debouncer.sv | 87 ++++++++
 rtl/keypad_entry_ctrl.sv | 179 +++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the keypad entry path:
//   - key codes produced by the debouncer (0..15 = single button index,
//     KEY_NONE = no button, KEY_MULTI = more than one button)
//   - function-key codes within the 0..15 range
//   - entry FSM state encoding
//   - small helpers for classifying key codes
package keypad_pkg;

    localparam logic [4:0] KEY_CLEAR = 5'd10;
    localparam logic [4:0] KEY_BACK  = 5'd11;
    localparam logic [4:0] KEY_ENTER = 5'd12;
    localparam logic [4:0] KEY_NONE  = 5'h1F;
    localparam logic [4:0] KEY_MULTI = 5'h1E;

    typedef enum logic [1:0] {
        S_WAIT_REL  = 2'd0,
        S_ARMED     = 2'd1,
        S_DEB_PRESS = 2'd2,
        S_ACT       = 2'd3
    } state_t;

    // Codes 0..9 are decimal digits.
    function automatic logic is_digit(input logic [4:0] code);
        return (code < 5'd10);
    endfunction

    // Codes 0..15 are one button pressed on its own.
    function automatic logic is_single(input logic [4:0] code);
        return (code < 5'd16);
    endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// keypad_debouncer
// Brings the 16 raw keypad lines into the clk_i domain, encodes them into a
// single key code and tracks how long that code has been unchanged.
// Ports:
//   clk_i    - oscillator clock
//   reset_n  - asynchronous active-low reset
//   buttons  - raw keypad lines, active-high, asynchronous
//   code     - encoded key: button index, KEY_NONE or KEY_MULTI
//   changed  - code differs from the previous cycle's code
//   stable   - code has been held for DEBOUNCE_CYCLES consecutive cycles
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20800
) (
    input  logic        clk_i,
    input  logic        reset_n,
    input  logic [15:0] buttons,
    output logic [4:0]  code,
    output logic        changed,
    output logic        stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // The counter saturates one short of DEBOUNCE_CYCLES: the cycle that
    // loads zero is itself the first cycle of the stable run.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [15:0]      sync1_reg;
    logic [15:0]      sync2_reg;
    logic [4:0]       prev_code_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [4:0] ones_cnt;
    logic [4:0] one_idx;

    // Two-stage synchronizer on all lines.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= buttons;
            sync2_reg <= sync1_reg;
        end
    end

    // One-hot validation: population count plus index of the set bit.
    always_comb begin
        ones_cnt = '0;
        one_idx  = '0;
        for (int i = 0; i < 16; i++) begin
            if (sync2_reg[i]) begin
                ones_cnt = ones_cnt + 5'd1;
                one_idx  = 5'(i);
            end
        end
    end

    always_comb begin
        if (ones_cnt == 5'd0) begin
            code = KEY_NONE;
        end else if (ones_cnt == 5'd1) begin
            code = one_idx;
        end else begin
            code = KEY_MULTI;
        end
    end

    assign changed = (code != prev_code_reg);
    assign stable  = !changed && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            prev_code_reg <= KEY_NONE;
            cnt_reg       <= '0;
        end else begin
            prev_code_reg <= code;
            if (changed) begin
                cnt_reg <= '0;
            end else if (cnt_reg != CNT_LAST) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
// Turns debounced keypad presses into digit-RAM writes, one action per press.
// Ports:
//   clk_i      - oscillator clock
//   reset_n    - asynchronous active-low reset
//   buttons    - raw keypad lines, active-high, asynchronous
//   mem_we     - RAM write enable, one-cycle pulse
//   mem_adr    - RAM address; idles at length, saturated to DEPTH-1
//   mem_din    - digit written (0-9)
//   length     - digits currently stored, 0..DEPTH
//   key_pulse  - one-cycle pulse per accepted key
//   key_code   - code of the last accepted key, KEY_NONE after reset
//   overflow   - one-cycle pulse when a digit is rejected because RAM is full
//   entry_done - high while entry is locked after ENTER, until CLEAR
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20800,
    parameter int DEPTH           = 8,
    parameter int ADR_W           = 3
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic [15:0]      buttons,
    output logic             mem_we,
    output logic [ADR_W-1:0] mem_adr,
    output logic [3:0]       mem_din,
    output logic [ADR_W:0]   length,
    output logic             key_pulse,
    output logic [4:0]       key_code,
    output logic             overflow,
    output logic             entry_done
);

    localparam logic [ADR_W:0]   DEPTH_L = (ADR_W + 1)'(DEPTH);
    localparam logic [ADR_W-1:0] ADR_MAX = ADR_W'(DEPTH - 1);

    logic [4:0] code;
    logic       changed;
    logic       stable;

    state_t           state_reg;
    logic [4:0]       key_cand_reg;
    logic             mem_we_reg;
    logic [ADR_W-1:0] mem_adr_reg;
    logic [3:0]       mem_din_reg;
    logic [ADR_W:0]   length_reg;
    logic             key_pulse_reg;
    logic [4:0]       key_code_reg;
    logic             overflow_reg;
    logic             entry_done_reg;

    // Action decode; only non-trivial while in S_ACT.
    logic             act_we_next;
    logic             act_ovf_next;
    logic [ADR_W:0]   length_next;
    logic             entry_done_next;
    logic [ADR_W-1:0] idle_adr_next;

    keypad_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .buttons (buttons),
        .code    (code),
        .changed (changed),
        .stable  (stable)
    );

    always_comb begin
        act_we_next     = 1'b0;
        act_ovf_next    = 1'b0;
        length_next     = length_reg;
        entry_done_next = entry_done_reg;
        if (state_reg == S_ACT) begin
            if (is_digit(key_cand_reg)) begin
                if (!entry_done_reg) begin
                    if (length_reg == DEPTH_L) begin
                        act_ovf_next = 1'b1;
                    end else begin
                        act_we_next = 1'b1;
                        length_next = length_reg + (ADR_W + 1)'(1);
                    end
                end
            end else begin
                case (key_cand_reg)
                    KEY_CLEAR: begin
                        length_next     = '0;
                        entry_done_next = 1'b0;
                    end
                    KEY_BACK: begin
                        // Stale RAM contents are left in place; only the
                        // length shrinks.
                        if ((length_reg != '0) && !entry_done_reg) begin
                            length_next = length_reg - (ADR_W + 1)'(1);
                        end
                    end
                    KEY_ENTER: begin
                        entry_done_next = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // When full, length equals DEPTH which is not a valid address.
    assign idle_adr_next = (length_next >= DEPTH_L) ? ADR_MAX : length_next[ADR_W-1:0];

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= S_WAIT_REL;
            key_cand_reg   <= KEY_NONE;
            mem_we_reg     <= 1'b0;
            mem_adr_reg    <= '0;
            mem_din_reg    <= '0;
            length_reg     <= '0;
            key_pulse_reg  <= 1'b0;
            key_code_reg   <= KEY_NONE;
            overflow_reg   <= 1'b0;
            entry_done_reg <= 1'b0;
        end else begin
            mem_we_reg    <= 1'b0;
            key_pulse_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            // During a write the address is the old length; otherwise it
            // tracks the (possibly updated) length.
            mem_adr_reg   <= act_we_next ? length_reg[ADR_W-1:0] : idle_adr_next;

            case (state_reg)
                S_WAIT_REL: begin
                    if ((code == KEY_NONE) && stable) begin
                        state_reg <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (is_single(code)) begin
                        key_cand_reg <= code;
                        state_reg    <= S_DEB_PRESS;
                    end
                end
                S_DEB_PRESS: begin
                    if (code != key_cand_reg) begin
                        state_reg <= S_ARMED;
                    end else if (stable) begin
                        state_reg <= S_ACT;
                    end
                end
                S_ACT: begin
                    mem_we_reg     <= act_we_next;
                    overflow_reg   <= act_ovf_next;
                    key_pulse_reg  <= 1'b1;
                    key_code_reg   <= key_cand_reg;
                    length_reg     <= length_next;
                    entry_done_reg <= entry_done_next;
                    if (act_we_next) begin
                        mem_din_reg <= key_cand_reg[3:0];
                    end
                    state_reg <= S_WAIT_REL;
                end
                default: begin
                    state_reg <= S_WAIT_REL;
                end
            endcase
        end
    end

    assign mem_we     = mem_we_reg;
    assign mem_adr    = mem_adr_reg;
    assign mem_din    = mem_din_reg;
    assign length     = length_reg;
    assign key_pulse  = key_pulse_reg;
    assign key_code   = key_code_reg;
    assign overflow   = overflow_reg;
    assign entry_done = entry_done_reg;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl
// Directed bench for keypad_entry_ctrl with a short debounce window.
module tb_keypad_entry_ctrl;

    localparam int DEB   = 4;
    localparam int DEPTH = 8;
    localparam int ADR_W = 3;

    logic             clk_i;
    logic             reset_n;
    logic [15:0]      buttons;
    logic             mem_we;
    logic [ADR_W-1:0] mem_adr;
    logic [3:0]       mem_din;
    logic [ADR_W:0]   length;
    logic             key_pulse;
    logic [4:0]       key_code;
    logic             overflow;
    logic             entry_done;

    int total = 0;
    int bad   = 0;

    // Event monitor, sampled on the falling edge.
    int we_cnt  = 0;
    int kp_cnt  = 0;
    int ovf_cnt = 0;
    int wr_adr_q[$];
    int wr_din_q[$];

    keypad_entry_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .DEPTH          (DEPTH),
        .ADR_W          (ADR_W)
    ) dut (
        .clk_i      (clk_i),
        .reset_n    (reset_n),
        .buttons    (buttons),
        .mem_we     (mem_we),
        .mem_adr    (mem_adr),
        .mem_din    (mem_din),
        .length     (length),
        .key_pulse  (key_pulse),
        .key_code   (key_code),
        .overflow   (overflow),
        .entry_done (entry_done)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (reset_n) begin
            if (mem_we) begin
                we_cnt = we_cnt + 1;
                wr_adr_q.push_back(int'(mem_adr));
                wr_din_q.push_back(int'(mem_din));
            end
            if (key_pulse) kp_cnt = kp_cnt + 1;
            if (overflow)  ovf_cnt = ovf_cnt + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total = total + 1;
        assert (obs === exp)
        else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Press a single pattern for 'hold' cycles, then release and let the
    // release debounce complete.
    task automatic press(input logic [15:0] pat, input int hold);
        @(negedge clk_i);
        buttons = pat;
        wait_neg(hold);
        buttons = '0;
        wait_neg(14);
        $display("press pattern=%04h -> length=%0d key_code=%0d entry_done=%0b writes=%0d pulses=%0d",
                 pat, length, key_code, entry_done, we_cnt, kp_cnt);
    endtask

    task automatic press_key(input int k);
        logic [15:0] pat;
        pat = 16'(1) << k;
        press(pat, 20);
    endtask

    task automatic chk_write(input string tag, input int idx, input int adr, input int din);
        int a;
        int d;
        a = -1;
        d = -1;
        if (idx < wr_adr_q.size()) begin
            a = wr_adr_q[idx];
            d = wr_din_q[idx];
        end
        chk({tag, "_adr"}, a, adr);
        chk({tag, "_din"}, d, din);
    endtask

    initial begin
        int lat;
        int we0;
        int kp0;
        buttons = '0;
        reset_n = 1'b0;
        wait_neg(3);

        // Reset state
        chk("rst_mem_we",     int'(mem_we),     0);
        chk("rst_mem_adr",    int'(mem_adr),    0);
        chk("rst_mem_din",    int'(mem_din),    0);
        chk("rst_length",     int'(length),     0);
        chk("rst_key_pulse",  int'(key_pulse),  0);
        chk("rst_key_code",   int'(key_code),   31);
        chk("rst_overflow",   int'(overflow),   0);
        chk("rst_entry_done", int'(entry_done), 0);

        reset_n = 1'b1;
        wait_neg(10);

        // Clean press of 5 with latency measurement: mem_we at the 8th
        // falling edge after the raw line rises (DEB+3 to S_ACT, +1 output).
        buttons = 16'(1) << 5;
        lat = 99;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_i);
            if (mem_we && lat == 99) lat = i;
        end
        buttons = '0;
        wait_neg(14);
        $display("press pattern=0020 -> length=%0d key_code=%0d latency=%0d", length, key_code, lat);
        chk("p5_latency",  lat, DEB + 4);
        chk("p5_we_cnt",   we_cnt, 1);
        chk_write("p5_wr", 0, 0, 5);
        chk("p5_length",   int'(length), 1);
        chk("p5_key_code", int'(key_code), 5);
        chk("p5_kp_cnt",   kp_cnt, 1);
        chk("p5_idle_adr", int'(mem_adr), 1);

        // Bouncing 3: toggles every 2 cycles never meet the stable window.
        @(negedge clk_i);
        for (int r = 0; r < 3; r++) begin
            buttons = 16'(1) << 3;
            wait_neg(2);
            buttons = '0;
            wait_neg(2);
        end
        chk("bounce_no_we", we_cnt, 1);
        chk("bounce_no_kp", kp_cnt, 1);
        press_key(3);
        chk("bounce_we_cnt", we_cnt, 2);
        chk_write("bounce_wr", 1, 1, 3);
        chk("bounce_length", int'(length), 2);

        // Clear, then fill to capacity and overflow.
        press_key(10);
        chk("clr_length", int'(length), 0);
        chk("clr_key_code", int'(key_code), 10);
        for (int k = 1; k <= 8; k++) press_key(k);
        chk("fill_we_cnt", we_cnt, 10);
        for (int k = 1; k <= 8; k++) chk_write($sformatf("fill%0d", k), 1 + k, k - 1, k);
        chk("fill_length", int'(length), 8);
        chk("fill_idle_adr", int'(mem_adr), 7);
        kp0 = kp_cnt;
        press_key(9);
        chk("ovf_cnt", ovf_cnt, 1);
        chk("ovf_no_we", we_cnt, 10);
        chk("ovf_length", int'(length), 8);
        chk("ovf_kp", kp_cnt, kp0 + 1);

        // 4, 7, BACKSPACE, 2
        press_key(10);
        press_key(4);
        press_key(7);
        press_key(11);
        chk("back_length", int'(length), 1);
        press_key(2);
        chk("b_we_cnt", we_cnt, 13);
        chk_write("b_wr0", 10, 0, 4);
        chk_write("b_wr1", 11, 1, 7);
        chk_write("b_wr2", 12, 1, 2);
        chk("b_length", int'(length), 2);

        // BACKSPACE at length 0
        press_key(10);
        kp0 = kp_cnt;
        press_key(11);
        chk("back0_length", int'(length), 0);
        chk("back0_kp", kp_cnt, kp0 + 1);
        chk("back0_we", we_cnt, 13);

        // Two buttons together: no accepted key.
        kp0 = kp_cnt;
        press((16'(1) << 2) | (16'(1) << 6), 20);
        chk("multi_no_kp", kp_cnt, kp0);
        chk("multi_key_code", int'(key_code), 11);

        // Ignored key 14 still pulses.
        press_key(14);
        chk("k14_kp", kp_cnt, kp0 + 1);
        chk("k14_code", int'(key_code), 14);
        chk("k14_length", int'(length), 0);

        // Digit, ENTER, then locked digit and backspace, then CLEAR.
        press_key(1);
        press_key(12);
        chk("enter_done", int'(entry_done), 1);
        chk("enter_length", int'(length), 1);
        we0 = we_cnt;
        press_key(9);
        chk("locked_no_we", we_cnt, we0);
        chk("locked_code", int'(key_code), 9);
        chk("locked_length", int'(length), 1);
        press_key(11);
        chk("locked_back", int'(length), 1);
        press_key(10);
        chk("clr_done", int'(entry_done), 0);
        chk("clr_length2", int'(length), 0);

        // Button 1 held through reset deassertion.
        press_key(7);
        chk("pre_rst_length", int'(length), 1);
        reset_n = 1'b0;
        buttons = 16'(1) << 1;
        wait_neg(3);
        reset_n = 1'b1;
        we0 = we_cnt;
        kp0 = kp_cnt;
        wait_neg(30);
        chk("held_no_kp", kp_cnt, kp0);
        chk("held_no_we", we_cnt, we0);
        chk("held_length", int'(length), 0);
        buttons = '0;
        wait_neg(14);
        press_key(1);
        chk("repress_we", we_cnt, we0 + 1);
        chk_write("repress_wr", we0, 0, 1);

        // Asynchronous reset while in S_DEB_PRESS.
        @(negedge clk_i);
        buttons = 16'(1) << 7;
        wait_neg(4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_length", int'(length), 0);
        chk("arst_key_code", int'(key_code), 31);
        chk("arst_mem_adr", int'(mem_adr), 0);
        chk("arst_mem_din", int'(mem_din), 0);
        we0 = we_cnt;
        kp0 = kp_cnt;
        wait_neg(3);
        buttons = '0;
        reset_n = 1'b1;
        wait_neg(20);
        chk("arst_no_we", we_cnt, we0);
        chk("arst_no_kp", kp_cnt, kp0);
        chk("arst_key_code2", int'(key_code), 31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
